bsg_8b10b_tx_sequencer: RTL and testbench

BSG_8B10B_TX_SEQUENCER -- requirements
Module: bsg_8b10b_tx_sequencer

---
 rtl/bsg_8b10b_pkg.sv | 30 +++
 rtl/bsg_8b10b_encode_comb.sv | 81 ++++++++
 rtl/bsg_8b10b_tx_sequencer.sv | 116 +++++++++++
 tb/tb_bsg_8b10b_tx_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_8b10b_pkg.sv
// Shared 8b/10b definitions: comma byte/codes, sequencer state enum, bit-order helpers.
// Latency: none (package only).
// Backpressure: not applicable.
package bsg_8b10b_pkg;

  // K28.5 comma byte and its two 10b code groups (bit 0 = a, bit 9 = j)
  localparam logic [7:0] k28_5_byte_gp   = 8'hBC;
  localparam logic [9:0] k28_5_rd_neg_gp = 10'h17C;
  localparam logic [9:0] k28_5_rd_pos_gp = 10'h283;

  // Transmit sequencer states: comma training, then user traffic
  typedef enum logic {
    e_sync = 1'b0,
    e_run  = 1'b1
  } tx_state_e;

  // Code tables are written abcdei / fghj left to right; the output puts a in bit 0
  function automatic logic [5:0] rev6(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
    return r;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

endpackage

// File: rtl/bsg_8b10b_encode_comb.sv
// Combinational 8b/10b encoder with running-disparity in/out and invalid-K flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides when the result is registered.
module bsg_8b10b_encode_comb
  import bsg_8b10b_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       k_i,
  input  logic       rd_i,
  output logic [9:0] data_o,
  output logic       rd_o,
  output logic       kerr_o
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] l6_neg, l6;
  logic [3:0] l4_neg, l4;
  logic       unbal6, unbal4, rd_mid, use_a7;

  // 5b/6b and 3b/4b lookup, RD- column stored, complemented when running positive
  always_comb begin
    x      = data_i[4:0];
    y      = data_i[7:5];
    l6_neg = 6'b000000;
    l4_neg = 4'b0000;

    case (x)
      5'd0:  l6_neg = 6'b100111;  5'd1:  l6_neg = 6'b011101;
      5'd2:  l6_neg = 6'b101101;  5'd3:  l6_neg = 6'b110001;
      5'd4:  l6_neg = 6'b110101;  5'd5:  l6_neg = 6'b101001;
      5'd6:  l6_neg = 6'b011001;  5'd7:  l6_neg = 6'b111000;
      5'd8:  l6_neg = 6'b111001;  5'd9:  l6_neg = 6'b100101;
      5'd10: l6_neg = 6'b010101;  5'd11: l6_neg = 6'b110100;
      5'd12: l6_neg = 6'b001101;  5'd13: l6_neg = 6'b101100;
      5'd14: l6_neg = 6'b011100;  5'd15: l6_neg = 6'b010111;
      5'd16: l6_neg = 6'b011011;  5'd17: l6_neg = 6'b100011;
      5'd18: l6_neg = 6'b010011;  5'd19: l6_neg = 6'b110010;
      5'd20: l6_neg = 6'b001011;  5'd21: l6_neg = 6'b101010;
      5'd22: l6_neg = 6'b011010;  5'd23: l6_neg = 6'b111010;
      5'd24: l6_neg = 6'b110011;  5'd25: l6_neg = 6'b100110;
      5'd26: l6_neg = 6'b010110;  5'd27: l6_neg = 6'b110110;
      5'd28: l6_neg = 6'b001110;  5'd29: l6_neg = 6'b101110;
      5'd30: l6_neg = 6'b011110;  default: l6_neg = 6'b101011;
    endcase
    if (k_i && (x == 5'd28)) l6_neg = 6'b001111;

    // D.7 is balanced but still has distinct RD-/RD+ forms
    unbal6 = ($countones(l6_neg) != 3);
    l6     = (rd_i && (unbal6 || (l6_neg == 6'b111000))) ? ~l6_neg : l6_neg;
    rd_mid = unbal6 ? ~rd_i : rd_i;

    // Alternate x.7 avoids a run of five identical bits across the sub-block edge
    use_a7 = (y == 3'd7) &&
             (k_i ||
              (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
              ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

    case (y)
      3'd0: l4_neg = 4'b1011;
      3'd1: l4_neg = k_i ? 4'b0110 : 4'b1001;
      3'd2: l4_neg = k_i ? 4'b1010 : 4'b0101;
      3'd3: l4_neg = 4'b1100;
      3'd4: l4_neg = 4'b1101;
      3'd5: l4_neg = k_i ? 4'b0101 : 4'b1010;
      3'd6: l4_neg = k_i ? 4'b1001 : 4'b0110;
      default: l4_neg = use_a7 ? 4'b0111 : 4'b1110;
    endcase

    // Every control 4b group flips with disparity, as does the balanced x.3
    unbal4 = ($countones(l4_neg) != 2);
    l4     = (rd_mid && (k_i || unbal4 || (l4_neg == 4'b1100))) ? ~l4_neg : l4_neg;
    rd_o   = unbal4 ? ~rd_mid : rd_mid;

    data_o = {rev4(l4), rev6(l6)};
    kerr_o = k_i && !((x == 5'd28) ||
                      ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                       (x == 5'd29) || (x == 5'd30))));
  end

endmodule

// File: rtl/bsg_8b10b_tx_sequencer.sv
// 8b/10b transmit sequencer: comma training after reset/resync, periodic commas, user words.
// Latency: one cycle from accepted word (or generated comma) to data_o.
// Backpressure: advances only on tx_yumi_i; ready_o is combinational from tx_yumi_i.
module bsg_8b10b_tx_sequencer
  import bsg_8b10b_pkg::*;
#(
  parameter int sync_count_p   = 16,
  parameter int comma_period_p = 256
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       resync_i,
  input  logic       v_i,
  input  logic [7:0] data_i,
  input  logic       k_i,
  output logic       ready_o,
  input  logic       tx_yumi_i,
  output logic [9:0] data_o,
  output logic       link_up_o,
  output logic       kerr_o
);

  localparam int sync_cnt_w_lp = $clog2(sync_count_p) + 1;
  localparam int gap_cnt_w_lp  = $clog2(comma_period_p) + 1;
  localparam logic [sync_cnt_w_lp-1:0] sync_init_lp = sync_cnt_w_lp'(sync_count_p);
  localparam logic [gap_cnt_w_lp-1:0]  gap_last_lp  =
    gap_cnt_w_lp'((comma_period_p == 0) ? 0 : comma_period_p - 1);
  localparam logic comma_en_lp = (comma_period_p != 0);

  tx_state_e                  state_r, state_n;
  logic [sync_cnt_w_lp-1:0]   sync_cnt_r, sync_cnt_n;
  logic [gap_cnt_w_lp-1:0]    gap_cnt_r, gap_cnt_n;
  logic [9:0]                 data_r;
  logic                       rd_r;
  logic                       kerr_r;

  logic       comma_due, send_user, user_is_comma;
  logic [7:0] enc_data;
  logic       enc_k;
  logic [9:0] enc_code;
  logic       enc_rd, enc_kerr;

  // Word selection: a due comma or resync wins over user data; idle fills with commas
  always_comb begin
    comma_due     = comma_en_lp && (gap_cnt_r == gap_last_lp);
    ready_o       = !reset_i && (state_r == e_run) && tx_yumi_i && !comma_due && !resync_i;
    send_user     = ready_o && v_i;
    user_is_comma = k_i && (data_i == k28_5_byte_gp);
    enc_data      = send_user ? data_i : k28_5_byte_gp;
    enc_k         = send_user ? k_i : 1'b1;
  end

  bsg_8b10b_encode_comb encoder (
    .data_i (enc_data),
    .k_i    (enc_k),
    .rd_i   (rd_r),
    .data_o (enc_code),
    .rd_o   (enc_rd),
    .kerr_o (enc_kerr)
  );

  // Next state and counters; resync restarts training whether or not a word leaves
  always_comb begin
    state_n    = state_r;
    sync_cnt_n = sync_cnt_r;
    gap_cnt_n  = gap_cnt_r;
    if (resync_i) begin
      state_n    = e_sync;
      sync_cnt_n = sync_init_lp;
      gap_cnt_n  = '0;
    end else if (tx_yumi_i) begin
      if (state_r == e_sync) begin
        sync_cnt_n = sync_cnt_r - sync_cnt_w_lp'(1);
        gap_cnt_n  = '0;
        if (sync_cnt_r == sync_cnt_w_lp'(1)) state_n = e_run;
      end else if (send_user && !user_is_comma) begin
        gap_cnt_n = gap_cnt_r + gap_cnt_w_lp'(1);
      end else begin
        gap_cnt_n = '0;
      end
    end
  end

  // Control state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_sync;
      sync_cnt_r <= sync_init_lp;
      gap_cnt_r  <= '0;
    end else begin
      state_r    <= state_n;
      sync_cnt_r <= sync_cnt_n;
      gap_cnt_r  <= gap_cnt_n;
    end
  end

  // Output word and disparity advance together only when the serializer takes a word
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_r <= k28_5_rd_neg_gp;
      rd_r   <= 1'b1;
      kerr_r <= 1'b0;
    end else begin
      if (tx_yumi_i) begin
        data_r <= enc_code;
        rd_r   <= enc_rd;
      end
      if (send_user && enc_kerr) kerr_r <= 1'b1;
    end
  end

  assign data_o    = data_r;
  assign link_up_o = (state_r == e_run);
  assign kerr_o    = kerr_r;

endmodule

// File: tb/tb_bsg_8b10b_tx_sequencer.sv
module tb_bsg_8b10b_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset_i, resync_i, v_i, k_i, tx_yumi_i;
  logic [7:0] data_i;
  logic       ready_o, link_up_o, kerr_o;
  logic [9:0] data_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bsg_8b10b_tx_sequencer #(.sync_count_p(4), .comma_period_p(4)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .resync_i  (resync_i),
    .v_i       (v_i),
    .data_i    (data_i),
    .k_i       (k_i),
    .ready_o   (ready_o),
    .tx_yumi_i (tx_yumi_i),
    .data_o    (data_o),
    .link_up_o (link_up_o),
    .kerr_o    (kerr_o)
  );

  // Hand-written code groups for the byte set used by the random run
  function automatic logic [8:0] decode(input logic [9:0] c);
    case (c)
      10'h155:          return {1'b1, 8'hB5};
      10'h2AA:          return {1'b1, 8'h4A};
      10'h263:          return {1'b1, 8'h23};
      10'h0B9, 10'h346: return {1'b1, 8'h00};
      default:          return 9'h000;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; resync_i = 1'b1; v_i = 1'b1; data_i = 8'h23; k_i = 1'b0; tx_yumi_i = 1'b1;
    #1;
    tests_run++;
    if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    cycle();
    tests_run++;
    if (data_o !== 10'h17C) begin tests_failed++; $display("FAIL reset_data: got %h want 17c", data_o); end
    tests_run++;
    if (link_up_o !== 1'b0) begin tests_failed++; $display("FAIL reset_link: got %b want 0", link_up_o); end
    tests_run++;
    if (kerr_o !== 1'b0) begin tests_failed++; $display("FAIL reset_kerr: got %b want 0", kerr_o); end
    cycle();
    tests_run++;
    if (data_o !== 10'h17C) begin tests_failed++; $display("FAIL reset_priority: got %h want 17c", data_o); end
    reset_i = 1'b0; resync_i = 1'b0; v_i = 1'b0; tx_yumi_i = 1'b0;
  endtask

  task automatic test_sync();
    logic [9:0] exp_d [4];
    exp_d = '{10'h283, 10'h17C, 10'h283, 10'h17C};
    tests_run++;
    if (data_o !== 10'h17C) begin tests_failed++; $display("FAIL sync_initial: got %h want 17c", data_o); end
    v_i = 1'b1; data_i = 8'h4A; k_i = 1'b0; tx_yumi_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL sync_ready[%0d]: got %b want 0", i, ready_o); end
      tests_run++;
      if (link_up_o !== 1'b0) begin tests_failed++; $display("FAIL sync_link[%0d]: got %b want 0", i, link_up_o); end
      cycle();
      tests_run++;
      if (data_o !== exp_d[i]) begin tests_failed++; $display("FAIL sync_data[%0d]: got %h want %h", i, data_o, exp_d[i]); end
    end
    tests_run++;
    if (link_up_o !== 1'b1) begin tests_failed++; $display("FAIL sync_link_up: got %b want 1", link_up_o); end
    tests_run++;
    if (kerr_o !== 1'b0) begin tests_failed++; $display("FAIL sync_kerr: got %b want 0", kerr_o); end
    v_i = 1'b0; tx_yumi_i = 1'b0;
  endtask

  // D0.0 is neutral, so its code only changes when a comma flips disparity
  task automatic test_data();
    logic       vv    [8];
    logic       exp_r [8];
    logic [9:0] exp_d [8];
    vv    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_d = '{10'h346, 10'h346, 10'h346, 10'h283, 10'h0B9, 10'h0B9, 10'h17C, 10'h346};
    data_i = 8'h00; k_i = 1'b0; tx_yumi_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v_i = vv[i];
      #1;
      tests_run++;
      if (ready_o !== exp_r[i]) begin tests_failed++; $display("FAIL data_ready[%0d]: got %b want %b", i, ready_o, exp_r[i]); end
      cycle();
      tests_run++;
      if (data_o !== exp_d[i]) begin tests_failed++; $display("FAIL data_code[%0d]: got %h want %h", i, data_o, exp_d[i]); end
    end
    v_i = 1'b0; tx_yumi_i = 1'b0;
  endtask

  task automatic test_comma_period();
    logic [7:0] bytes [6];
    logic       exp_r [8];
    logic [9:0] exp_d [8];
    int idx;
    bytes = '{8'hB5, 8'h4A, 8'h23, 8'h00, 8'hB5, 8'h4A};
    exp_r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d = '{10'h155, 10'h2AA, 10'h263, 10'h17C, 10'h346, 10'h155, 10'h2AA, 10'h283};
    // idle comma first so the gap count starts from zero
    v_i = 1'b0; tx_yumi_i = 1'b1;
    cycle();
    tests_run++;
    if (data_o !== 10'h283) begin tests_failed++; $display("FAIL period_idle: got %h want 283", data_o); end
    idx = 0;
    v_i = 1'b1; k_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_i = bytes[idx];
      #1;
      tests_run++;
      if (ready_o !== exp_r[i]) begin tests_failed++; $display("FAIL period_ready[%0d]: got %b want %b", i, ready_o, exp_r[i]); end
      cycle();
      tests_run++;
      if (data_o !== exp_d[i]) begin tests_failed++; $display("FAIL period_code[%0d]: got %h want %h", i, data_o, exp_d[i]); end
      if (exp_r[i]) idx++;
    end
    v_i = 1'b0; tx_yumi_i = 1'b0;
  endtask

  task automatic test_resync();
    logic [9:0] exp_d [4];
    exp_d = '{10'h283, 10'h17C, 10'h283, 10'h17C};
    v_i = 1'b1; data_i = 8'hB5; k_i = 1'b0; tx_yumi_i = 1'b1; resync_i = 1'b1;
    #1;
    tests_run++;
    if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL resync_ready: got %b want 0", ready_o); end
    cycle();
    resync_i = 1'b0;
    tests_run++;
    if (data_o !== 10'h17C) begin tests_failed++; $display("FAIL resync_comma: got %h want 17c", data_o); end
    tests_run++;
    if (link_up_o !== 1'b0) begin tests_failed++; $display("FAIL resync_link_down: got %b want 0", link_up_o); end
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL resync_train_ready[%0d]: got %b want 0", i, ready_o); end
      cycle();
      tests_run++;
      if (data_o !== exp_d[i]) begin tests_failed++; $display("FAIL resync_train[%0d]: got %h want %h", i, data_o, exp_d[i]); end
    end
    tests_run++;
    if (link_up_o !== 1'b1) begin tests_failed++; $display("FAIL resync_link_up: got %b want 1", link_up_o); end
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL resync_ready_back: got %b want 1", ready_o); end
    cycle();
    tests_run++;
    if (data_o !== 10'h155) begin tests_failed++; $display("FAIL resync_held_word: got %h want 155", data_o); end
    v_i = 1'b0; tx_yumi_i = 1'b0;
  endtask

  task automatic test_kerr();
    logic [9:0] exp_d [3];
    exp_d = '{10'h283, 10'h17C, 10'h283};
    v_i = 1'b1; k_i = 1'b1; data_i = 8'h00; tx_yumi_i = 1'b1;
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin tests_failed++; $display("FAIL kerr_ready: got %b want 1", ready_o); end
    cycle();
    v_i = 1'b0; k_i = 1'b0;
    tests_run++;
    if (kerr_o !== 1'b1) begin tests_failed++; $display("FAIL kerr_set: got %b want 1", kerr_o); end
    tests_run++;
    if (data_o !== 10'h346) begin tests_failed++; $display("FAIL kerr_word: got %h want 346", data_o); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (data_o !== exp_d[i]) begin tests_failed++; $display("FAIL kerr_stream[%0d]: got %h want %h", i, data_o, exp_d[i]); end
      tests_run++;
      if (kerr_o !== 1'b1) begin tests_failed++; $display("FAIL kerr_sticky[%0d]: got %b want 1", i, kerr_o); end
    end
    tx_yumi_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4];
    logic [9:0] prev;
    logic       hs;
    bytes = '{8'hB5, 8'h4A, 8'h23, 8'h00};
    prev   = data_o;
    k_i    = 1'b0;
    data_i = bytes[$urandom_range(0, 3)];
    for (int i = 0; i < 300; i++) begin
      tx_yumi_i = 1'($urandom_range(0, 1));
      v_i       = 1'($urandom_range(0, 1));
      #1;
      hs = v_i && ready_o;
      if (!tx_yumi_i) begin
        tests_run++;
        if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL rand_ready_noyumi[%0d]: got %b want 0", i, ready_o); end
      end
      cycle();
      if (!tx_yumi_i) begin
        tests_run++;
        if (data_o !== prev) begin tests_failed++; $display("FAIL rand_stable[%0d]: got %h want %h", i, data_o, prev); end
      end else if (hs) begin
        tests_run++;
        if (decode(data_o) !== {1'b1, data_i}) begin
          tests_failed++; $display("FAIL rand_order[%0d]: got code %h want byte %h", i, data_o, data_i);
        end
        data_i = bytes[$urandom_range(0, 3)];
      end else begin
        tests_run++;
        if ((data_o !== 10'h17C) && (data_o !== 10'h283)) begin
          tests_failed++; $display("FAIL rand_comma[%0d]: got %h want 17c or 283", i, data_o);
        end
      end
      prev = data_o;
    end
    v_i = 1'b0; tx_yumi_i = 1'b0;
  endtask

  task automatic test_reset_clear();
    reset_i = 1'b1; v_i = 1'b1; data_i = 8'hB5; tx_yumi_i = 1'b1;
    #1;
    tests_run++;
    if (ready_o !== 1'b0) begin tests_failed++; $display("FAIL rst2_ready: got %b want 0", ready_o); end
    cycle();
    reset_i = 1'b0; v_i = 1'b0;
    tests_run++;
    if (kerr_o !== 1'b0) begin tests_failed++; $display("FAIL rst2_kerr: got %b want 0", kerr_o); end
    tests_run++;
    if (link_up_o !== 1'b0) begin tests_failed++; $display("FAIL rst2_link: got %b want 0", link_up_o); end
    tests_run++;
    if (data_o !== 10'h17C) begin tests_failed++; $display("FAIL rst2_data: got %h want 17c", data_o); end
    cycle();
    tests_run++;
    if (data_o !== 10'h283) begin tests_failed++; $display("FAIL rst2_first_comma: got %h want 283", data_o); end
    tx_yumi_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sync();
    test_data();
    test_comma_period();
    test_resync();
    test_kerr();
    test_back_to_back();
    test_reset_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
